// File: rtl/mc_pkg.sv
// Shared encodings for the multi-cycle MIPS control unit: opcodes, functs,
// ALU operations, mux selects, FSM states and latched instruction classes.
package mc_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_SLT  = 6'h2A;

  localparam logic [3:0] ALU_ADD = 4'd0;
  localparam logic [3:0] ALU_SUB = 4'd1;
  localparam logic [3:0] ALU_SLL = 4'd2;
  localparam logic [3:0] ALU_SRL = 4'd3;
  localparam logic [3:0] ALU_SLT = 4'd4;
  localparam logic [3:0] ALU_OR  = 4'd5;
  localparam logic [3:0] ALU_LUI = 4'd6;

  localparam logic [1:0] PC_SEQ    = 2'd0;
  localparam logic [1:0] PC_BRANCH = 2'd1;
  localparam logic [1:0] PC_JUMP   = 2'd2;

  localparam logic [1:0] REG_RT = 2'd0;
  localparam logic [1:0] REG_RD = 2'd1;
  localparam logic [1:0] REG_RA = 2'd2;

  typedef enum logic [2:0] {
    ST_RST, ST_FETCH, ST_DECODE, ST_EXEC, ST_MEM, ST_WB, ST_TRAP
  } state_t;

  typedef enum logic [3:0] {
    CL_ADDU, CL_SUBU, CL_SLL, CL_SRL, CL_SLT,
    CL_ORI, CL_SLTI, CL_LUI, CL_LW, CL_SW,
    CL_BEQ, CL_BNE, CL_J, CL_JAL
  } iclass_t;

  function automatic logic [3:0] alu_op_of(input iclass_t c);
    logic [3:0] op;
    op = ALU_ADD;
    case (c)
      CL_SUBU, CL_BEQ, CL_BNE: op = ALU_SUB;
      CL_SLL:                  op = ALU_SLL;
      CL_SRL:                  op = ALU_SRL;
      CL_SLT, CL_SLTI:         op = ALU_SLT;
      CL_ORI:                  op = ALU_OR;
      CL_LUI:                  op = ALU_LUI;
      default:                 op = ALU_ADD;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/mc_decode.sv
// Combinational opcode/funct classifier; flags anything the control unit
// cannot sequence so DECODE can divert to TRAP.
module mc_decode
  import mc_pkg::*;
#(
  parameter int unsigned EN_JAL = 1
) (
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output iclass_t    iclass,
  output logic       illegal
);

  always_comb begin
    iclass  = CL_ADDU;
    illegal = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        case (funct)
          FN_ADDU: iclass = CL_ADDU;
          FN_SUBU: iclass = CL_SUBU;
          FN_SLL:  iclass = CL_SLL;
          FN_SRL:  iclass = CL_SRL;
          FN_SLT:  iclass = CL_SLT;
          default: illegal = 1'b1;
        endcase
      end
      OP_ORI:  iclass = CL_ORI;
      OP_SLTI: iclass = CL_SLTI;
      OP_LUI:  iclass = CL_LUI;
      OP_LW:   iclass = CL_LW;
      OP_SW:   iclass = CL_SW;
      OP_BEQ:  iclass = CL_BEQ;
      OP_BNE:  iclass = CL_BNE;
      OP_J:    iclass = CL_J;
      OP_JAL: begin
        iclass  = CL_JAL;
        illegal = (EN_JAL == 0);
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle MIPS control FSM: sequences FETCH/DECODE/EXEC/MEM/WB with
// req/ack memory handshakes, traps on illegal instructions, counts retires.
module multicycle_control
  import mc_pkg::*;
#(
  parameter int unsigned ALUOP_W = 4,
  parameter int unsigned CNT_W   = 32,
  parameter int unsigned EN_JAL  = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [5:0]         opcode,
  input  logic [5:0]         funct,
  input  logic               alu_zero,
  input  logic               imem_ack,
  input  logic               dmem_ack,
  output logic               imem_req,
  output logic               dmem_req,
  output logic               ir_write,
  output logic               pc_write,
  output logic [1:0]         pc_src,
  output logic [1:0]         reg_dst,
  output logic               alu_src,
  output logic               ext_op,
  output logic               mem2reg,
  output logic               link,
  output logic [ALUOP_W-1:0] alu_op,
  output logic               reg_write,
  output logic               mem_write,
  output logic               trap,
  output logic [CNT_W-1:0]   instret
);

  state_t           state, state_nx;
  iclass_t          cls, dec_cls;
  logic             dec_ill;
  logic             retire;
  logic [3:0]       alu_sel;
  logic [CNT_W-1:0] count;

  mc_decode #(.EN_JAL(EN_JAL)) u_decode (
    .opcode  (opcode),
    .funct   (funct),
    .iclass  (dec_cls),
    .illegal (dec_ill)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_RST;
    else        state <= state_nx;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                  cls <= CL_ADDU;
    else if (state == ST_DECODE) cls <= dec_cls;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      count <= '0;
    else if (retire) count <= count + CNT_W'(1);
  end

  always_comb begin
    state_nx  = state;
    imem_req  = 1'b0;
    dmem_req  = 1'b0;
    ir_write  = 1'b0;
    pc_write  = 1'b0;
    pc_src    = PC_SEQ;
    reg_write = 1'b0;
    mem_write = 1'b0;
    link      = 1'b0;
    trap      = 1'b0;
    retire    = 1'b0;
    reg_dst   = REG_RT;
    alu_src   = 1'b0;
    ext_op    = 1'b0;
    mem2reg   = 1'b0;
    alu_sel   = ALU_ADD;

    // Datapath levels are held from EXEC through WB off the latched class.
    if (state inside {ST_EXEC, ST_MEM, ST_WB}) begin
      case (cls)
        CL_ADDU, CL_SUBU, CL_SLL, CL_SRL, CL_SLT: reg_dst = REG_RD;
        CL_ORI, CL_LUI:                           alu_src = 1'b1;
        CL_SLTI, CL_LW, CL_SW: begin
          alu_src = 1'b1;
          ext_op  = 1'b1;
        end
        CL_BEQ, CL_BNE:                           ext_op  = 1'b1;
        default: ;
      endcase
      mem2reg = (cls == CL_LW);
      alu_sel = alu_op_of(cls);
    end

    case (state)
      ST_RST: state_nx = ST_FETCH;
      ST_FETCH: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_nx = ST_DECODE;
        end
      end
      ST_DECODE: state_nx = dec_ill ? ST_TRAP : ST_EXEC;
      ST_EXEC: begin
        case (cls)
          CL_BEQ, CL_BNE: begin
            pc_write = (cls == CL_BEQ) ? alu_zero : !alu_zero;
            pc_src   = PC_BRANCH;
            state_nx = ST_FETCH;
            retire   = 1'b1;
          end
          CL_J, CL_JAL: begin
            pc_write = 1'b1;
            pc_src   = PC_JUMP;
            state_nx = ST_FETCH;
            retire   = 1'b1;
            if (cls == CL_JAL) begin
              reg_write = 1'b1;
              reg_dst   = REG_RA;
              link      = 1'b1;
            end
          end
          CL_LW, CL_SW: state_nx = ST_MEM;
          default:      state_nx = ST_WB;
        endcase
      end
      ST_MEM: begin
        dmem_req  = 1'b1;
        mem_write = (cls == CL_SW);
        if (dmem_ack) begin
          state_nx = (cls == CL_SW) ? ST_FETCH : ST_WB;
          retire   = (cls == CL_SW);
        end
      end
      ST_WB: begin
        reg_write = 1'b1;
        state_nx  = ST_FETCH;
        retire    = 1'b1;
      end
      ST_TRAP: trap = 1'b1;
      default: state_nx = ST_RST;
    endcase
  end

  assign alu_op  = ALUOP_W'(alu_sel);
  assign instret = count;

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Multi-cycle successor to the single-cycle MIPS instruction decoder. It sequences each instruction through FETCH/DECODE/EXEC/MEM/WB states and drives the datapath control levels and one-cycle write strobes. Instruction and data memory are accessed through req/ack handshakes, so variable-latency memories are supported. It also traps on unsupported opcodes and counts retired instructions; it sits between the instruction register and the shared multi-cycle datapath.

## Interface
Parameters:
- ALUOP_W, 4: width of alu_op.
- CNT_W, 32: width of the retired-instruction counter.
- EN_JAL, 1: 1 enables JAL (opcode 0x03); 0 makes JAL illegal.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- opcode  in  6  IR[31:26]; stable from DECODE until the next FETCH ack.
- funct  in  6  IR[5:0]; same validity as opcode.
- alu_zero  in  1  ALU zero flag; valid in EXEC.
- imem_ack  in  1  instruction fetch complete; may assert in the same cycle as imem_req.
- dmem_ack  in  1  data access complete; may assert in the same cycle as dmem_req.
- imem_req  out  1  fetch request level.
- dmem_req  out  1  data request level.
- ir_write, pc_write  out  1  one-cycle strobes.
- pc_src  out  2  0 = PC+4, 1 = branch target, 2 = jump target.
- reg_dst  out  2  0 = rt, 1 = rd, 2 = r31 (JAL).
- alu_src, ext_op, mem2reg, link  out  1  datapath levels.
- alu_op  out  ALUOP_W  ALU operation, encoded per package.
- reg_write, mem_write  out  1  one-cycle strobes.
- trap  out  1  sticky illegal-instruction flag.
- instret  out  CNT_W  retired-instruction count.

## Operation
- States: RST, FETCH, DECODE, EXEC, MEM, WB, TRAP. Reset enters RST; RST moves to FETCH unconditionally.
- FETCH: imem_req=1. In the cycle imem_ack=1: ir_write=1, pc_write=1, pc_src=0, then go to DECODE. Otherwise stay.
- DECODE:
  - Latch the instruction class from opcode/funct: ADDU, SUBU, SLL, SRL, SLT, ORI, SLTI, LUI, LW, SW, BEQ, BNE, J, JAL.
  - Unsupported opcode, unsupported R-type funct, or JAL with EN_JAL=0: go to TRAP.
  - All other classes: go to EXEC.
- EXEC, by class:
  - BEQ: pc_write=alu_zero, pc_src=1, go to FETCH, retire.
  - BNE: pc_write=!alu_zero, pc_src=1, go to FETCH, retire.
  - J: pc_write=1, pc_src=2, go to FETCH, retire.
  - JAL: same as J, plus reg_write=1, reg_dst=2, link=1.
  - LW, SW: go to MEM.
  - All others: go to WB.
- MEM: dmem_req=1; mem_write=1 for SW. On dmem_ack: SW goes to FETCH and retires; LW goes to WB. Otherwise stay.
- WB: reg_write=1, go to FETCH, retire.
- TRAP: trap=1, all strobes and requests 0. Leaves only on reset.
- Levels (alu_src, ext_op, reg_dst, mem2reg, alu_op) come from the latched class and are valid EXEC through WB:
  - R-type: reg_dst=1, alu_src=0.
  - ORI: ext_op=zero, alu_src=1, reg_dst=0.
  - SLTI, LW, SW: ext_op=sign, alu_src=1.
  - LUI: alu_src=1, mem2reg=0, no memory access.
  - LW: mem2reg=1.
  - BEQ, BNE: alu_op=SUB, alu_src=0, ext_op=sign.
- instret increments by 1 in each retire cycle and wraps modulo 2^CNT_W.

## Timing
- Reset: state=RST, instret=0, trap=0, all outputs 0. imem_req first rises one cycle after rst_n deasserts.
- All outputs are Moore decodes of registered state and class, so there is no input-to-output combinational path. The exceptions are pc_write in BEQ/BNE (depends on alu_zero) and ir_write/pc_write in FETCH (depend on imem_ack).
- Latency with zero-wait memory:
  - BEQ, BNE, J, JAL: 3 cycles.
  - R-type, ORI, SLTI, LUI, SW: 4 cycles.
  - LW: 5 cycles.
  - Each ack wait cycle adds 1.
- req stays high until ack. An ack while req=0 is ignored. A request is never dropped.
- rst_n asserted mid-instruction: immediate return to RST. Strobes drop asynchronously and no partial write-back is issued.
- An instret wrap occurring in a retire cycle reads 0 on the following cycle.

## Structure
- Shared package `mc_pkg`: opcode/funct constants, alu_op encodings, state enum, instruction-class enum, pc_src/reg_dst encodings.
- Sub-module `mc_decode`: combinational opcode/funct to {class, illegal}. It is instantiated once and its output is latched in DECODE.

## Test plan
- Reset release, zero-wait memory, ADDU (funct 0x21) -> ir_write at cycle 1, reg_write=1 with reg_dst=1 at cycle 4, instret=1.
- LW with dmem_ack delayed 3 cycles -> dmem_req high 4 cycles, mem_write=0, reg_write with mem2reg=1 one cycle after ack, total 8 cycles.
- BEQ with alu_zero=1, then BNE with alu_zero=1 -> pc_write=1 with pc_src=1 for BEQ; pc_write=0 for BNE; both retire in 3 cycles.
- Opcode 0x3F, then 0x03 with EN_JAL=0 -> trap=1 after DECODE, no further imem_req, instret unchanged; rst_n low clears trap.
- JAL with EN_JAL=1 -> pc_src=2, reg_write=1, reg_dst=2, link=1 in EXEC.
- rst_n pulsed during a SW MEM wait; CNT_W=4 run of 16 instructions -> mem_write drops at once and state returns to RST; instret wraps to 0.
